// File: rtl/disp_frame_ctrl.sv
// Double-buffered frame controller feeding the 8x8 matrix scan driver; blanks between scans and swaps tear-free.
// Optional checkerboard test pattern via `define DISP_TEST_PATTERN_EN (adds input test_i).
module disp_frame_ctrl #(
   parameter int gs        = 8,
   parameter int BLANK_CYC = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               enable_i,
   input  logic [gs*gs-1:0]   frame_i,
   input  logic               frame_valid_i,
   output logic               frame_ready_o,
   output logic [gs*gs-1:0]   matrix_o,
   output logic               e_disp_o,
   input  logic               d_disp_i,
`ifdef DISP_TEST_PATTERN_EN
   input  logic               test_i,
`endif
   output logic               swap_o,
   output logic               err_o,
   output logic [1:0]         state_o
);

   localparam int N    = gs * gs;
   localparam int SC_W = $clog2(gs + 2) + 1;
   localparam int BC_W = $clog2(BLANK_CYC - 1) + 1;

   localparam logic [SC_W-1:0] SCAN_MAX   = SC_W'(gs + 2);
   localparam logic [BC_W-1:0] BLANK_LAST = BC_W'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2
   } state_t;

   // Handshake: a frame is taken on any clock edge where frame_valid_i and
   // frame_ready_o are both high; frame_ready_o depends only on registered state.

   state_t            state_q, state_d;
   logic [SC_W-1:0]   scan_cnt_q;
   logic [BC_W-1:0]   blank_cnt_q;
   logic              pending_q;
   logic [N-1:0]      back_q;
   logic [N-1:0]      matrix_q;
   logic              e_disp_q;
   logic              err_q;

   logic              accept;
   logic              blank_first;
   logic              timeout;
   logic              ld_back;
   logic              ld_test;

`ifdef DISP_TEST_PATTERN_EN
   function automatic logic [N-1:0] checker_pat();
      logic [N-1:0] p;
      p = '0;
      for (int r = 0; r < gs; r++) begin
         for (int c = 0; c < gs; c++) begin
            p[gs*r+c] = ((r ^ c) & 1) != 0;
         end
      end
      return p;
   endfunction

   localparam logic [N-1:0] CHECKER = checker_pat();
`endif

   assign accept      = frame_valid_i && !pending_q;
   assign blank_first = (state_q == BLANK) && (blank_cnt_q == '0);
   // d_disp_i wins over a simultaneous timeout: the scan finished normally.
   assign timeout     = (state_q == SCAN) && enable_i && !d_disp_i && (scan_cnt_q == SCAN_MAX);

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable_i) state_d = BLANK;
         end
         SCAN: begin
            if (d_disp_i || (scan_cnt_q == SCAN_MAX)) state_d = BLANK;
         end
         BLANK: begin
            if (blank_cnt_q == BLANK_LAST) state_d = SCAN;
         end
         default: state_d = IDLE;
      endcase
      if (!enable_i) state_d = IDLE;
   end

   // Output / load decode; the first BLANK cycle swaps even if enable_i drops in it.
   always_comb begin
      ld_back = 1'b0;
      ld_test = 1'b0;
`ifdef DISP_TEST_PATTERN_EN
      if (blank_first && test_i) begin
         ld_test = 1'b1;
      end else if (blank_first && pending_q) begin
         ld_back = 1'b1;
      end
`else
      if (blank_first && pending_q) begin
         ld_back = 1'b1;
      end
`endif
      swap_o = ld_back || ld_test;
   end

   // Counters are cleared on every state exit, so they never wrap.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scan_cnt_q  <= '0;
         blank_cnt_q <= '0;
      end else begin
         scan_cnt_q  <= ((state_q == SCAN) && (state_d == SCAN)) ? scan_cnt_q + 1'b1 : '0;
         blank_cnt_q <= ((state_q == BLANK) && (state_d == BLANK)) ? blank_cnt_q + 1'b1 : '0;
      end
   end

   // Back buffer and pending flag; accept and swap are mutually exclusive.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         back_q    <= '0;
         pending_q <= 1'b0;
      end else if (accept) begin
         back_q    <= frame_i;
         pending_q <= 1'b1;
      end else if (ld_back) begin
         pending_q <= 1'b0;
      end
   end

   // Front buffer only changes in BLANK, keeping it stable through every scan.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         matrix_q <= '0;
      end else if (ld_back) begin
         matrix_q <= back_q;
`ifdef DISP_TEST_PATTERN_EN
      end else if (ld_test) begin
         matrix_q <= CHECKER;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         e_disp_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         e_disp_q <= (state_d == SCAN);
         if (timeout) err_q <= 1'b1;
      end
   end

   assign frame_ready_o = !pending_q;
   assign matrix_o      = matrix_q;
   assign e_disp_o      = e_disp_q;
   assign err_o         = err_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_disp_frame_ctrl.sv
// Bench for disp_frame_ctrl: per-cycle vector table, multi-cycle corner sequences and a frame scoreboard.
// Define DISP_TEST_PATTERN_EN for both files to exercise the checkerboard path.
module tb_disp_frame_ctrl;

   localparam int GS    = 8;
   localparam int BLANK = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd2;

   localparam logic [63:0] FR_F = 64'h00FF_0000_0000_FF00;
   localparam logic [63:0] FR_G = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] FR_H = 64'hA5A5_0F0F_F0F0_5A5A;
   localparam logic [63:0] FR_J = 64'hDEAD_BEEF_0BAD_F00D;
   localparam logic [63:0] FR_A = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] FR_B = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] FR_K = 64'h0F1E_2D3C_4B5A_6978;
   localparam logic [63:0] CHK  = 64'h55AA_55AA_55AA_55AA;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        enable_i;
   logic [63:0] frame_i;
   logic        frame_valid_i;
   logic        frame_ready_o;
   logic [63:0] matrix_o;
   logic        e_disp_o;
   logic        d_disp_i;
   logic        test_i;
   logic        swap_o;
   logic        err_o;
   logic [1:0]  state_o;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   logic [63:0] cur_exp;

   disp_frame_ctrl #(.gs(GS), .BLANK_CYC(BLANK)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .enable_i      (enable_i),
      .frame_i       (frame_i),
      .frame_valid_i (frame_valid_i),
      .frame_ready_o (frame_ready_o),
      .matrix_o      (matrix_o),
      .e_disp_o      (e_disp_o),
      .d_disp_i      (d_disp_i),
`ifdef DISP_TEST_PATTERN_EN
      .test_i        (test_i),
`endif
      .swap_o        (swap_o),
      .err_o         (err_o),
      .state_o       (state_o)
   );

   // Clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Driver tasks
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("rst_matrix", matrix_o, 64'd0);
      chk("rst_e_disp", {63'd0, e_disp_o}, 64'd0);
      chk("rst_ready", {63'd0, frame_ready_o}, 64'd1);
      chk("rst_err", {63'd0, err_o}, 64'd0);
      chk("rst_swap", {63'd0, swap_o}, 64'd0);
      chk("rst_state", {62'd0, state_o}, {62'd0, ST_IDLE});
      enable_i      = 1'b0;
      frame_valid_i = 1'b0;
      frame_i       = '0;
      d_disp_i      = 1'b0;
      test_i        = 1'b0;
      step();
      step();
      rst_n_i = 1'b1;
   endtask

   // Counts cycles with e_disp_o low, starting from the current observation.
   task automatic wait_scan(output int n_low);
      n_low = 0;
      for (int k = 0; k < 40; k++) begin
         if (e_disp_o) break;
         n_low++;
         step();
      end
   endtask

   // Driver model: raises d_disp_i in the done_at-th scan cycle (0 = never).
   task automatic run_scan(input int done_at, output int n_high);
      n_high = 0;
      for (int k = 0; k < 40; k++) begin
         if (!e_disp_o) break;
         n_high++;
         d_disp_i = (n_high == done_at);
         step();
      end
      d_disp_i = 1'b0;
   endtask

   // Scoreboard: every accepted frame is queued; each swap pops the value matrix_o must show next.
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         exp_q.delete();
         cur_exp = '0;
      end else begin
         chk("mon_matrix", matrix_o, cur_exp);
         if (swap_o) begin
            if (test_i) begin
               cur_exp = CHK;
            end else if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL mon_underflow: got swap want no swap");
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         if (frame_valid_i && frame_ready_o) exp_q.push_back(frame_i);
      end
   end

   typedef struct {
      logic        en;
      logic        fv;
      logic [63:0] frame;
      logic        dd;
      logic        exp_e;
      logic        exp_sw;
      logic        exp_rdy;
      logic [63:0] exp_m;
      logic        exp_err;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic fv, input logic [63:0] fr, input logic dd,
                               input logic ee, input logic es, input logic er,
                               input logic [63:0] em, input logic eerr);
      vec_t v;
      v.en = en; v.fv = fv; v.frame = fr; v.dd = dd;
      v.exp_e = ee; v.exp_sw = es; v.exp_rdy = er; v.exp_m = em; v.exp_err = eerr;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      int n;

      // Inputs applied before edge i, outputs expected just after it.
      tbl[0]  = mk(1, 1, FR_F, 0, 0, 1, 0, 64'd0, 0);
      tbl[1]  = mk(1, 0, 64'd0, 0, 0, 0, 1, FR_F, 0);
      tbl[2]  = mk(1, 0, 64'd0, 0, 0, 0, 1, FR_F, 0);
      tbl[3]  = mk(1, 0, 64'd0, 0, 0, 0, 1, FR_F, 0);
      tbl[4]  = mk(1, 0, 64'd0, 0, 1, 0, 1, FR_F, 0);
      tbl[5]  = mk(1, 0, 64'd0, 0, 1, 0, 1, FR_F, 0);
      tbl[6]  = mk(1, 1, FR_G, 0, 1, 0, 0, FR_F, 0);
      tbl[7]  = mk(1, 0, 64'd0, 0, 1, 0, 0, FR_F, 0);
      for (int i = 8; i <= 12; i++) tbl[i] = mk(1, 1, FR_H, 0, 1, 0, 0, FR_F, 0);
      tbl[13] = mk(1, 1, FR_H, 1, 0, 1, 0, FR_F, 0);
      tbl[14] = mk(1, 1, FR_H, 0, 0, 0, 1, FR_G, 0);
      tbl[15] = mk(1, 1, FR_H, 0, 0, 0, 0, FR_G, 0);
      tbl[16] = mk(1, 0, 64'd0, 0, 0, 0, 0, FR_G, 0);
      tbl[17] = mk(1, 0, 64'd0, 0, 1, 0, 0, FR_G, 0);

      // Reset block
      rst_n_i       = 1'b0;
      enable_i      = 1'b0;
      frame_i       = '0;
      frame_valid_i = 1'b0;
      d_disp_i      = 1'b0;
      test_i        = 1'b0;
      cur_exp       = '0;
      step();
      step();
      chk("init_matrix", matrix_o, 64'd0);
      chk("init_e_disp", {63'd0, e_disp_o}, 64'd0);
      chk("init_ready", {63'd0, frame_ready_o}, 64'd1);
      chk("init_err", {63'd0, err_o}, 64'd0);
      chk("init_swap", {63'd0, swap_o}, 64'd0);
      chk("init_state", {62'd0, state_o}, {62'd0, ST_IDLE});
      rst_n_i = 1'b1;

      // Basic display, second write during scan, third write held off.
      for (int i = 0; i < 18; i++) begin
         enable_i      = tbl[i].en;
         frame_valid_i = tbl[i].fv;
         frame_i       = tbl[i].frame;
         d_disp_i      = tbl[i].dd;
         step();
         chk($sformatf("v%0d_e_disp", i), {63'd0, e_disp_o}, {63'd0, tbl[i].exp_e});
         chk($sformatf("v%0d_swap", i), {63'd0, swap_o}, {63'd0, tbl[i].exp_sw});
         chk($sformatf("v%0d_ready", i), {63'd0, frame_ready_o}, {63'd0, tbl[i].exp_rdy});
         chk($sformatf("v%0d_matrix", i), matrix_o, tbl[i].exp_m);
         chk($sformatf("v%0d_err", i), {63'd0, err_o}, {63'd0, tbl[i].exp_err});
      end
      frame_valid_i = 1'b0;
      d_disp_i      = 1'b0;

      // Timeout: scan_cnt runs 0..gs+2 with e_disp high, so gs+3 high cycles.
      run_scan(0, n);
      chk("timeout_len", 64'(n), 64'(GS + 3));
      chk("timeout_err", {63'd0, err_o}, 64'd1);
      chk("timeout_swap", {63'd0, swap_o}, 64'd1);
      wait_scan(n);
      chk("blank_len_1", 64'(n), 64'(BLANK));
      chk("matrix_h", matrix_o, FR_H);
      run_scan(9, n);
      chk("scan_len_1", 64'(n), 64'd9);
      chk("err_sticky", {63'd0, err_o}, 64'd1);

      // Reset mid-frame with a pending frame: it is lost.
      frame_valid_i = 1'b1;
      frame_i       = FR_J;
      step();
      frame_valid_i = 1'b0;
      chk("pend_before_rst", {63'd0, frame_ready_o}, 64'd0);
      do_reset();

      // Disable mid-scan keeps the pending frame; re-enable swaps it first.
      enable_i      = 1'b1;
      frame_valid_i = 1'b1;
      frame_i       = FR_A;
      step();
      frame_valid_i = 1'b0;
      chk("a_swap", {63'd0, swap_o}, 64'd1);
      wait_scan(n);
      chk("blank_len_2", 64'(n), 64'(BLANK));
      chk("matrix_a", matrix_o, FR_A);
      frame_valid_i = 1'b1;
      frame_i       = FR_B;
      step();
      frame_valid_i = 1'b0;
      chk("b_pending", {63'd0, frame_ready_o}, 64'd0);
      step();
      enable_i = 1'b0;
      step();
      chk("dis_e_disp", {63'd0, e_disp_o}, 64'd0);
      chk("dis_state", {62'd0, state_o}, {62'd0, ST_IDLE});
      chk("dis_ready", {63'd0, frame_ready_o}, 64'd0);
      chk("dis_matrix", matrix_o, FR_A);
      d_disp_i = 1'b1;
      step();
      d_disp_i = 1'b0;
      chk("idle_dd_state", {62'd0, state_o}, {62'd0, ST_IDLE});
      chk("idle_dd_e_disp", {63'd0, e_disp_o}, 64'd0);

      // Enable drop in the first BLANK cycle: swap still completes.
      enable_i = 1'b1;
      step();
      chk("reen_state", {62'd0, state_o}, {62'd0, ST_BLANK});
      chk("reen_swap", {63'd0, swap_o}, 64'd1);
      chk("reen_matrix", matrix_o, FR_A);
      enable_i = 1'b0;
      step();
      chk("drop_matrix", matrix_o, FR_B);
      chk("drop_state", {62'd0, state_o}, {62'd0, ST_IDLE});
      chk("drop_ready", {63'd0, frame_ready_o}, 64'd1);
      chk("drop_swap", {63'd0, swap_o}, 64'd0);
      enable_i = 1'b1;
      step();
      chk("nopend_swap", {63'd0, swap_o}, 64'd0);
      wait_scan(n);
      chk("blank_len_3", 64'(n), 64'(BLANK));
      run_scan(9, n);
      chk("scan_len_2", 64'(n), 64'd9);
      chk("no_err", {63'd0, err_o}, 64'd0);

`ifdef DISP_TEST_PATTERN_EN
      // Checkerboard load leaves the pending back buffer in place.
      enable_i      = 1'b0;
      frame_valid_i = 1'b1;
      frame_i       = FR_K;
      step();
      frame_valid_i = 1'b0;
      test_i        = 1'b1;
      enable_i      = 1'b1;
      step();
      chk("tp_swap", {63'd0, swap_o}, 64'd1);
      step();
      chk("tp_matrix", matrix_o, CHK);
      chk("tp_ready", {63'd0, frame_ready_o}, 64'd0);
      test_i = 1'b0;
      wait_scan(n);
      run_scan(9, n);
      chk("tp_k_swap", {63'd0, swap_o}, 64'd1);
      step();
      chk("tp_k_matrix", matrix_o, FR_K);
`endif

      step();
      // Final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
